fp12_mult_arbiter: RTL and testbench



---
 rtl/fp12_pkg.sv | 40 ++++
 rtl/fp12_mult.sv | 34 +++
 rtl/fp12_mult_arbiter.sv | 98 +++++++++
 tb/tb_fp12_mult_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp12_pkg.sv
// Shared FP12 definitions: format constants, the packed fp12_t type and the
// round-robin grant helper used by the multiplier arbiter.
package fp12_pkg;

    localparam int FP12_W     = 12;
    localparam int FP12_POINT = 8;
    localparam int FP12_BIAS  = 7;
    localparam int FP12_EXP_W = FP12_W - FP12_POINT;

    // Widest supported requester set; narrower arbiters zero-pad into it.
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [FP12_EXP_W-1:0] expo;
        logic [FP12_POINT-1:0] mant;
    } fp12_t;

    // Search starts one past `last` and wraps modulo MAX_REQ. Zero-padded
    // upper bits are skipped, so the order equals wrapping modulo NUM_REQ.
    function automatic logic [MAX_REQ-1:0] rr_next_grant(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] last
    );
        logic [MAX_REQ-1:0]  grant;
        logic [MAX_ID_W-1:0] idx;
        logic                found;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = last + MAX_ID_W'(k);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fp12_mult.sv
// Combinational FP12 multiplier: implicit leading one, single-step
// normalisation, truncation, exponent arithmetic modulo 2^FP12_EXP_W.
module fp12_mult
    import fp12_pkg::*;
#(
    parameter int POINT = FP12_POINT,
    parameter int BIAS  = FP12_BIAS
) (
    input  fp12_t a_i,
    input  fp12_t b_i,
    output fp12_t p_o
);

    localparam int MW = POINT + 1;
    localparam int PW = 2 * MW;

    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic [PW-1:0] prod;
    logic          norm;

    assign ma   = {1'b1, a_i.mant};
    assign mb   = {1'b1, b_i.mant};
    assign prod = PW'(ma) * PW'(mb);

    // Product of two [1,2) significands lies in [1,4): the top bit picks the shift.
    assign norm = prod[PW-1];

    always_comb begin
        p_o.mant = norm ? prod[PW-2:POINT+1] : prod[PW-3:POINT];
        p_o.expo = a_i.expo + b_i.expo - FP12_EXP_W'(BIAS) + FP12_EXP_W'(norm);
    end

endmodule

// File: rtl/fp12_mult_arbiter.sv
// Round-robin arbiter feeding one shared FP12 multiplier through a two-stage
// issue/result pipeline; a global stall freezes every stage without loss.
module fp12_mult_arbiter
    import fp12_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FP12_W-1:0] req_in1,
    input  logic [NUM_REQ*FP12_W-1:0] req_in2,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [FP12_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      busy
);

    logic [ID_W-1:0]    last_q;
    logic               s1_valid_q;
    logic [ID_W-1:0]    s1_id_q;
    fp12_t              s1_in1_q;
    fp12_t              s1_in2_q;
    logic               s2_valid_q;
    logic [ID_W-1:0]    s2_id_q;
    fp12_t              s2_data_q;

    logic [MAX_REQ-1:0] rr_grant;
    logic [NUM_REQ-1:0] grant;
    logic               s1_valid_d;
    logic [ID_W-1:0]    s1_id_d;
    fp12_t              s1_in1_d;
    fp12_t              s1_in2_d;
    fp12_t              mult_p;

    // NOTE: every signal gets a default before the conditional logic below;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        rr_grant   = rr_next_grant(MAX_REQ'(req_valid), MAX_ID_W'(last_q));
        grant      = (rst || stall) ? '0 : rr_grant[NUM_REQ-1:0];
        s1_valid_d = |grant;
        s1_id_d    = '0;
        s1_in1_d   = '0;
        s1_in2_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                s1_id_d  = ID_W'(i);
                s1_in1_d = req_in1[i*FP12_W +: FP12_W];
                s1_in2_d = req_in2[i*FP12_W +: FP12_W];
            end
        end
    end

    fp12_mult #(
        .POINT (FP12_POINT),
        .BIAS  (FP12_BIAS)
    ) u_mult (
        .a_i (s1_in1_q),
        .b_i (s1_in2_q),
        .p_o (mult_p)
    );

    // NOTE: non-blocking assignments let S2 sample the pre-edge S1 contents,
    // which is what makes this a two-register pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= ID_W'(NUM_REQ - 1);
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_in1_q   <= '0;
            s1_in2_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_data_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_in1_q   <= s1_in1_d;
            s1_in2_q   <= s1_in2_d;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_data_q  <= mult_p;
            if (s1_valid_d) begin
                last_q <= s1_id_d;
            end
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (s2_valid_q && !stall) ? (NUM_REQ'(1) << s2_id_q) : '0;
    assign resp_data  = s2_data_q;
    assign resp_id    = s2_id_q;
    assign busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_fp12_mult_arbiter.sv
// Directed bench for fp12_mult_arbiter: reset, latency, round-robin order,
// fairness, stall hold/replay, mid-flight reset and multiplier corner cases.
module tb_fp12_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ*12-1:0] req_in1;
    logic [NUM_REQ*12-1:0] req_in2;
    logic [NUM_REQ-1:0]  req_ready;
    logic                stall;
    logic [NUM_REQ-1:0]  resp_valid;
    logic [11:0]         resp_data;
    logic [ID_W-1:0]     resp_id;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    fp12_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_ready  (req_ready),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        req_in1[12*i +: 12] = a;
        req_in2[12*i +: 12] = b;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; req_valid = 4'b1111; req_in1 = '0; req_in2 = '0;
        tick; tick;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        checks++; if (resp_data !== 12'h000) begin failures++; $display("FAIL reset_resp_data: got %h want 000", resp_data); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0; req_valid = '0;
        #1;
    endtask

    task automatic test_single;
        set_op(0, 12'h780, 12'h780);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick;
        req_valid = '0;
        #1;
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL single_early: got %b want 0000", resp_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
        tick;
        checks++; if (resp_valid !== 4'b0001) begin failures++; $display("FAIL single_resp_valid: got %b want 0001", resp_valid); end
        checks++; if (resp_data !== 12'h820) begin failures++; $display("FAIL single_resp_data: got %h want 820", resp_data); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL single_resp_id: got %0d want 0", resp_id); end
        tick;
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL single_dup: got %b want 0000", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_round_robin;
        logic [11:0] exp_p [4];
        logic [3:0]  exp_oh;
        exp_p[0] = 12'h700;  // 1.0 * 1.0
        exp_p[1] = 12'h8FE;  // carry/normalise case
        exp_p[2] = 12'h880;  // 1.5 * 2.0
        exp_p[3] = 12'h820;  // 1.5 * 1.5
        rst = 1'b1; req_valid = '0; tick; rst = 1'b0;
        set_op(0, 12'h700, 12'h700);
        set_op(1, 12'h7FF, 12'h7FF);
        set_op(2, 12'h780, 12'h800);
        set_op(3, 12'h780, 12'h780);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp_oh = 4'b0001 << (c % 4);
            checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, exp_oh); end
            tick;
            if (c > 0) begin
                exp_oh = 4'b0001 << ((c - 1) % 4);
                checks++; if (resp_valid !== exp_oh) begin failures++; $display("FAIL rr_resp_valid[%0d]: got %b want %b", c - 1, resp_valid, exp_oh); end
                checks++; if (resp_data !== exp_p[(c - 1) % 4]) begin failures++; $display("FAIL rr_resp_data[%0d]: got %h want %h", c - 1, resp_data, exp_p[(c - 1) % 4]); end
                checks++; if (resp_id !== 2'((c - 1) % 4)) begin failures++; $display("FAIL rr_resp_id[%0d]: got %0d want %0d", c - 1, resp_id, (c - 1) % 4); end
            end
        end
        req_valid = '0;
        tick;
        checks++; if (resp_valid !== 4'b1000) begin failures++; $display("FAIL rr_last_valid: got %b want 1000", resp_valid); end
        checks++; if (resp_data !== 12'h820) begin failures++; $display("FAIL rr_last_data: got %h want 820", resp_data); end
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_drain_busy: got %b want 0", busy); end
    endtask

    task automatic test_starvation;
        logic [3:0] exp_oh;
        int         n1;
        int         n3;
        n1 = 0; n3 = 0;
        rst = 1'b1; req_valid = '0; tick; rst = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL starve_prime: got %b want 0010", req_ready); end
        tick;
        req_valid = 4'b1010;
        for (int c = 0; c < 20; c++) begin
            #1;
            exp_oh = (c % 2 == 0) ? 4'b1000 : 4'b0010;
            checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL starve_grant[%0d]: got %b want %b", c, req_ready, exp_oh); end
            if (req_ready[1]) n1++;
            if (req_ready[3]) n3++;
            tick;
        end
        checks++; if (n1 != 10 || n3 != 10) begin failures++; $display("FAIL starve_count: got req1=%0d req3=%0d want 10/10", n1, n3); end
        req_valid = '0;
        tick; tick; tick;
    endtask

    task automatic test_stall;
        set_op(0, 12'h780, 12'h780);
        set_op(1, 12'h7FF, 12'h7FF);
        set_op(2, 12'h700, 12'h700);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL stall_fill_a: got %b want 0001", req_ready); end
        tick;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL stall_fill_b: got %b want 0010", req_ready); end
        tick;
        stall = 1'b1; req_valid = 4'b0100;
        #1;
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL stall_resp0: got %b want 0000", resp_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready0: got %b want 0000", req_ready); end
        checks++; if (resp_data !== 12'h820) begin failures++; $display("FAIL stall_hold_data: got %h want 820", resp_data); end
        for (int s = 1; s < 3; s++) begin
            tick;
            checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL stall_resp%0d: got %b want 0000", s, resp_valid); end
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready%0d: got %b want 0000", s, req_ready); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy%0d: got %b want 1", s, busy); end
        end
        tick;
        stall = 1'b0; req_valid = '0;
        #1;
        checks++; if (resp_valid !== 4'b0001) begin failures++; $display("FAIL stall_out_a_valid: got %b want 0001", resp_valid); end
        checks++; if (resp_data !== 12'h820) begin failures++; $display("FAIL stall_out_a_data: got %h want 820", resp_data); end
        tick;
        checks++; if (resp_valid !== 4'b0010) begin failures++; $display("FAIL stall_out_b_valid: got %b want 0010", resp_valid); end
        checks++; if (resp_data !== 12'h8FE) begin failures++; $display("FAIL stall_out_b_data: got %h want 8FE", resp_data); end
        checks++; if (resp_id !== 2'd1) begin failures++; $display("FAIL stall_out_b_id: got %0d want 1", resp_id); end
        tick;
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL stall_dup: got %b want 0000", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        set_op(2, 12'h700, 12'h700);
        set_op(3, 12'h780, 12'h800);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_accept2: got %b want 0100", req_ready); end
        tick;
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rmid_accept3: got %b want 1000", req_ready); end
        tick;
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rmid_ready_in_rst: got %b want 0000", req_ready); end
        tick;
        rst = 1'b0; req_valid = '0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL rmid_ghost[%0d]: got %b want 0000", c, resp_valid); end
            tick;
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_next_grant: got %b want 0001", req_ready); end
        tick;
        req_valid = '0;
        tick;
        checks++; if (resp_valid !== 4'b0001) begin failures++; $display("FAIL rmid_resp_valid: got %b want 0001", resp_valid); end
        checks++; if (resp_data !== 12'h820) begin failures++; $display("FAIL rmid_resp_data: got %h want 820", resp_data); end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_starvation;
        test_stall;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
